// File: rtl/axi4_lite_sram_slave.sv
// axi4_lite_sram_slave: AXI4-Lite responder backed by an internal word-addressed SRAM.
// Read and write channels run independent FSMs, each inserting a response delay to
// model slow memory. Out-of-range accesses answer DECERR and never touch the array.
// Optional build macro: AXI_SRAM_RAND_DELAY_EN -- delays come from a free-running
// 16-bit Fibonacci LFSR (low 3 bits) instead of READ_DELAY/WRITE_DELAY.
module axi4_lite_sram_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned READ_DELAY  = 2,
    parameter int unsigned WRITE_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    // read address channel
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    // read data channel
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    // write address channel
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    // write data channel
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    // write response channel
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W      = 4;
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_DEC   = 2'b11;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_t;

    // Offset is taken modulo 2^32, so addresses below BASE_ADDR wrap high and fail the compare.
    function automatic logic addr_hit(input logic [31:0] a);
        return (a - BASE_ADDR) < SPAN_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    logic [CNT_W-1:0] rd_delay;
    logic [CNT_W-1:0] wr_delay;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr_q;

    // Free-running LFSR, taps 16,14,13,11; advances every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign rd_delay = {1'b0, lfsr_q[2:0]};
    assign wr_delay = {1'b0, lfsr_q[2:0]};
`else
    assign rd_delay = CNT_W'(READ_DELAY);
    assign wr_delay = CNT_W'(WRITE_DELAY);
`endif

    // ------------------------------------------------------------------ read side
    r_state_t         r_state_q, r_state_d;
    logic [IDX_W-1:0] r_idx_q, r_idx_d;
    logic             r_hit_q, r_hit_d;
    logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
    logic [31:0]      rdata_d;
    logic [1:0]       rresp_d;
    logic             arready_d, rvalid_d;

    // Read state register and registered read-channel outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_hit_q   <= 1'b0;
            r_cnt_q   <= '0;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_hit_q   <= r_hit_d;
            r_cnt_q   <= r_cnt_d;
            arready   <= arready_d;
            rvalid    <= rvalid_d;
            rdata     <= rdata_d;
            rresp     <= rresp_d;
        end
    end

    // Read next-state logic.
    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE:  if (arvalid && arready) r_state_d = R_WAIT;
            R_WAIT:  if (r_cnt_q == '0)      r_state_d = R_RESP;
            R_RESP:  if (rready)             r_state_d = R_IDLE;
            default:                         r_state_d = R_IDLE;
        endcase
    end

    // Read datapath and next values of the registered read outputs.
    always_comb begin
        r_idx_d = r_idx_q;
        r_hit_d = r_hit_q;
        r_cnt_d = r_cnt_q;
        rdata_d = rdata;
        rresp_d = rresp;
        unique case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready) begin
                    r_idx_d = addr_idx(araddr);
                    r_hit_d = addr_hit(araddr);
                    r_cnt_d = rd_delay;
                end
            end
            R_WAIT: begin
                if (r_cnt_q != '0) begin
                    r_cnt_d = r_cnt_q - CNT_W'(1);
                end else begin
                    // A write committing at this same edge is not yet visible: old data wins.
                    rdata_d = r_hit_q ? mem[r_idx_q] : 32'h0;
                    rresp_d = r_hit_q ? RESP_OKAY : RESP_DEC;
                end
            end
            default: ;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_RESP);
    end

    // ----------------------------------------------------------------- write side
    w_state_t         w_state_q, w_state_d;
    logic             aw_got_q, aw_got_d;
    logic             w_got_q, w_got_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic             w_hit_q, w_hit_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
    logic [1:0]       bresp_d;
    logic             awready_d, wready_d, bvalid_d;
    logic             mem_we;
    logic             aw_hs, w_hs;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Write state register, captured AW/W payload and registered write-channel outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            w_idx_q   <= '0;
            w_hit_q   <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            w_cnt_q   <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            w_idx_q   <= w_idx_d;
            w_hit_q   <= w_hit_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            w_cnt_q   <= w_cnt_d;
            awready   <= awready_d;
            wready    <= wready_d;
            bvalid    <= bvalid_d;
            bresp     <= bresp_d;
        end
    end

    // Write next-state logic; AW and W may complete in either order or together.
    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE:  if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) w_state_d = W_WAIT;
            W_WAIT:  if (w_cnt_q == '0)                            w_state_d = W_RESP;
            W_RESP:  if (bready)                                   w_state_d = W_IDLE;
            default:                                               w_state_d = W_IDLE;
        endcase
    end

    // Write datapath, SRAM write enable and next values of the registered write outputs.
    always_comb begin
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        w_idx_d  = w_idx_q;
        w_hit_d  = w_hit_q;
        w_data_d = w_data_q;
        w_strb_d = w_strb_q;
        w_cnt_d  = w_cnt_q;
        bresp_d  = bresp;
        mem_we   = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    w_idx_d  = addr_idx(awaddr);
                    w_hit_d  = addr_hit(awaddr);
                end
                if (w_hs) begin
                    w_got_d  = 1'b1;
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                end
                if (w_state_d == W_WAIT) w_cnt_d = wr_delay;
            end
            W_WAIT: begin
                if (w_cnt_q != '0) begin
                    w_cnt_d = w_cnt_q - CNT_W'(1);
                end else begin
                    mem_we  = w_hit_q;
                    bresp_d = w_hit_q ? RESP_OKAY : RESP_DEC;
                end
            end
            W_RESP: begin
                if (bready) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                end
            end
            default: ;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_got_d;
        wready_d  = (w_state_d == W_IDLE) && !w_got_d;
        bvalid_d  = (w_state_d == W_RESP);
    end

    // SRAM byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb_q[i]) mem[w_idx_q][8*i +: 8] <= w_data_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Self-checking bench for axi4_lite_sram_slave (default build, fixed delays).
// Directed scenarios followed by randomized traffic against a word-array model.
module tb_axi4_lite_sram_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          RD   = 2;
    localparam int          WD   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int total = 0;
    int bad   = 0;
    int last_ar_wait = 0;

    logic [31:0] model [int];

    axi4_lite_sram_slave #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (BASE),
        .READ_DELAY (RD),
        .WRITE_DELAY(WD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // w_lead > 0: W offered that many cycles before AW; < 0: AW leads; 0: together.
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input logic [1:0] exp_resp);
        int c, aw_start, w_start, last;
        bit aw_d, w_d, hs_aw, hs_w, to;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        c = 0; aw_d = 0; w_d = 0; to = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_d && w_d)) begin
            awvalid = !aw_d && (c >= aw_start);
            wvalid  = !w_d && (c >= w_start);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1; c++;
            if (hs_aw) aw_d = 1;
            if (hs_w)  w_d  = 1;
            if (w_d && !aw_d) chk({tag, "_wready_drop"}, 32'(wready), 0);
            if (aw_d && !w_d) chk({tag, "_awready_drop"}, 32'(awready), 0);
            if (c > 100) begin to = 1; break; end
        end
        awvalid = 0; wvalid = 0;
        last = c;
        while (!to && !bvalid) begin
            @(posedge clk); #1; c++;
            if (c - last > 100) to = 1;
        end
        chk({tag, "_timeout"}, 32'(to), 0);
        if (!to) begin
            chk({tag, "_blat"}, 32'(c - last), 32'(WD + 1));
            chk({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
            bready = 1;
            @(posedge clk); #1;
            bready = 0;
            chk({tag, "_bclear"}, 32'(bvalid), 0);
            chk({tag, "_ready_back"}, 32'({awready, wready}), 32'(2'b11));
        end
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int hold);
        int c, last;
        bit hs, to;
        c = 0; to = 0;
        araddr = addr; arvalid = 1;
        forever begin
            hs = arvalid && arready;
            @(posedge clk); #1; c++;
            if (hs) break;
            if (c > 100) begin to = 1; break; end
        end
        arvalid = 0;
        last_ar_wait = c;
        last = c;
        while (!to && !rvalid) begin
            @(posedge clk); #1; c++;
            if (c - last > 100) to = 1;
        end
        chk({tag, "_timeout"}, 32'(to), 0);
        if (!to) begin
            chk({tag, "_rlat"}, 32'(c - last), 32'(RD + 1));
            chk({tag, "_rdata"}, rdata, exp_data);
            chk({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_rdata"}, rdata, exp_data);
                chk({tag, "_hold_rresp"}, 32'(rresp), 32'(exp_resp));
                chk({tag, "_hold_rvalid"}, 32'(rvalid), 1);
                chk({tag, "_hold_arready"}, 32'(arready), 0);
            end
            rready = 1;
            @(posedge clk); #1;
            rready = 0;
            chk({tag, "_rclear"}, 32'(rvalid), 0);
            chk({tag, "_arready_back"}, 32'(arready), 1);
        end
    endtask

    initial begin
        int k, op, lead;
        logic [31:0] d, a;
        logic [3:0]  s;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readies", 32'({arready, awready, wready}), 0);
        chk("rst_valids", 32'({rvalid, bvalid}), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resps", 32'({rresp, bresp}), 0);
        rst = 1;
        @(posedge clk); #1;

        // full write then readback
        axi_write("w_full", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 2'b00);
        model[4] = 32'hDEAD_BEEF;
        axi_read("r_full", 32'h8000_0010, model[4], 2'b00, 0);

        // partial strobe merge
        axi_write("w_base", 32'h8000_0020, 32'h1122_3344, 4'hF, -1, 2'b00);
        model[8] = 32'h1122_3344;
        axi_write("w_part", 32'h8000_0020, 32'h0000_AB00, 4'b0010, 0, 2'b00);
        model[8] = merge(model[8], 32'h0000_AB00, 4'b0010);
        axi_read("r_part", 32'h8000_0023, 32'h1122_AB44, 2'b00, 0);

        // W three cycles ahead of AW
        axi_write("w_lead", 32'h8000_0030, 32'hCAFE_F00D, 4'hF, 3, 2'b00);
        model[12] = 32'hCAFE_F00D;
        axi_read("r_lead", 32'h8000_0030, model[12], 2'b00, 0);

        // out-of-range read and write; aliased word 0 must stay intact
        axi_write("w_w0", 32'h8000_0000, 32'h5A5A_5A5A, 4'hF, 0, 2'b00);
        model[0] = 32'h5A5A_5A5A;
        axi_read("r_oor", 32'h7FFF_FFFC, 32'h0, 2'b11, 0);
        axi_write("w_oor", 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 2'b11);
        axi_read("r_w0", 32'h8000_0000, model[0], 2'b00, 0);

        // back-pressure on R, next AR accepted right after
        axi_read("r_hold", 32'h8000_0010, model[4], 2'b00, 10);
        axi_read("r_after", 32'h8000_0020, model[8], 2'b00, 0);
        chk("ar_accept_next", 32'(last_ar_wait), 1);

        // reset during R_WAIT
        araddr = 32'h8000_0010; arvalid = 1;
        k = 0;
        while (!arready && k < 20) begin @(posedge clk); #1; k++; end
        chk("rstmid_arready", 32'(arready), 1);
        @(posedge clk); #1;
        arvalid = 0;
        @(posedge clk); #1;
        rst = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rstmid_rvalid", 32'(rvalid), 0);
            chk("rstmid_arready_low", 32'(arready), 0);
            @(posedge clk); #1;
        end
        rst = 1;
        @(posedge clk); #1;
        chk("rstmid_arready_up", 32'(arready), 1);
        for (int i = 0; i < RD + 4; i++) begin
            chk("rstmid_no_stale", 32'(rvalid), 0);
            @(posedge clk); #1;
        end

        // randomized traffic over a 16-word window at word 0x40
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            axi_write("rw_init", BASE + 32'h100 + 32'(4 * i), d, 4'hF, 0, 2'b00);
            model[64 + i] = d;
        end
        for (int n = 0; n < 60; n++) begin
            op   = $urandom_range(0, 4);
            k    = $urandom_range(0, 15);
            d    = $urandom;
            s    = 4'($urandom_range(0, 15));
            lead = $urandom_range(0, 6) - 3;
            a    = BASE + 32'h100 + 32'(4 * k) + 32'($urandom_range(0, 3));
            case (op)
                0, 1: begin
                    axi_write("rw_wr", a, d, s, lead, 2'b00);
                    model[64 + k] = merge(model[64 + k], d, s);
                end
                2: axi_read("rw_rd", a, model[64 + k], 2'b00, $urandom_range(0, 2));
                3: axi_write("rw_wr_oor", a + 32'h1000, d, s, lead, 2'b11);
                default: axi_read("rw_rd_oor", BASE - 32'(4 * (k + 1)), 32'h0, 2'b11, 0);
            endcase
        end
        for (int i = 0; i < 16; i++) begin
            axi_read("rw_final", BASE + 32'h100 + 32'(4 * i), model[64 + i], 2'b00, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_sram_slave.md
# axi4_lite_sram_slave

AXI4-Lite responder backed by an internal word-addressed SRAM array. It sits on the slave side of the AXI4-Lite arbiter and serves the instruction and data masters as the single downstream memory. Its read and write channels are handled by independent state machines. A configurable response delay models slow memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- BASE_ADDR, 32'h8000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- READ_DELAY, 2: extra wait cycles between AR handshake and rvalid (0..15).
- WRITE_DELAY, 2: extra wait cycles between AW+W capture and bvalid (0..15).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- araddr  in  32  read address.
- arvalid  in  1  / arready  out  1  read address handshake.
- rdata  out  32 / rresp  out  2  read data and response.
- rvalid  out  1 / rready  in  1  read data handshake.
- awaddr  in  32  write address.
- awvalid  in  1 / awready  out  1  write address handshake.
- wdata  in  32 / wstrb  in  4  write data and byte strobes.
- wvalid  in  1 / wready  out  1  write data handshake.
- bresp  out  2  write response.
- bvalid  out  1 / bready  in  1  write response handshake.

## Operation
- All outputs are registered. Reset values: arready=awready=wready=0, rvalid=bvalid=0, rdata=0, rresp=0, bresp=0. SRAM contents are not reset.
- Address decode: in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS. Word index = (addr-BASE_ADDR)>>2. addr[1:0] is ignored.
- Read FSM: R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
  - R_IDLE: arready=1. On arvalid&arready, latch the address and load the delay counter.
  - R_WAIT: count down. When the count reaches 0, sample SRAM into rdata and set rvalid. rresp=2'b00 for in range; 2'b11 (DECERR) and rdata=0 for out of range.
  - R_RESP: hold rdata/rresp stable until rvalid&rready, then clear rvalid and return to R_IDLE.
- Write FSM: W_IDLE -> W_WAIT -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. The two captures complete in either order or in the same cycle, and each ready drops the cycle after its handshake.
  - W_WAIT: entered once both are captured; count down the delay.
  - W_RESP: entered at count 0. At that edge, write the bytes with wstrb[i]=1 (byte i = wdata[8i+7:8i]) if in range, and set bvalid. bresp=2'b00 for in range; 2'b11 for out of range, with no write.
  - On bvalid&bready, clear bvalid and return to W_IDLE.
- Read and write collision to the same word in the same cycle: the read samples the old data; the write commits at the same edge.
- Reset asserted mid-transaction: both FSMs return to idle immediately, pending responses are dropped, and any uncommitted write is lost.

## Timing
- AR handshake at edge T: rvalid rises at edge T+1+READ_DELAY. Best case, a read holds the channel 2 cycles when rready is held high.
- Last of AW/W captured at edge T: bvalid rises at edge T+1+WRITE_DELAY; the SRAM is updated at that same edge.
- arready is high again the cycle after R handshake completes; the same holds for awready/wready after B handshake. No back-to-back overlap: one outstanding read and one outstanding write at most.
- Back-pressure: rready/bready low holds the FSM in R_RESP/W_RESP indefinitely, with outputs unchanged.

## Configuration
- AXI_SRAM_RAND_DELAY_EN defined: READ_DELAY/WRITE_DELAY are ignored. Each delay is instead the low 3 bits (0..7) of a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1). The LFSR advances every cycle. The delay is sampled at the AR handshake, or at the edge the write enters W_WAIT.
- Undefined: fixed delays from the parameters; no LFSR is present.

## Test plan
- Write 0xDEADBEEF to 0x8000_0010 with wstrb=4'hF, then read it back -> bresp=0; rdata=0xDEADBEEF, rresp=0; rvalid exactly READ_DELAY+1 cycles after AR handshake.
- Partial write wstrb=4'b0010, wdata=0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
- W presented 3 cycles before AW (same data) -> single write; bvalid WRITE_DELAY+1 cycles after AW handshake.
- Read 0x7FFF_FFFC and write to 0x8000_1000 (DEPTH_WORDS=1024) -> rresp=2'b11, rdata=0; bresp=2'b11; SRAM unchanged.
- rready held low 10 cycles after rvalid -> rdata/rresp stable, arready=0 throughout; the next AR is accepted the cycle after rready.
- Assert rst during R_WAIT of a read -> rvalid stays 0 and arready=0 while in reset; arready=1 one cycle after deassert; no stale response.
